alu_handshake: RTL and testbench
================================

# alu_handshake

Parametrised, handshaked successor to the system's register-output ALU. It accepts one operation per transfer on a valid/ready input port and produces a registered 2×DATA_WIDTH result with status flags on a valid/ready output port. Division is iterative and multi-cycle, which lets wider datapaths meet timing. It sits between the UART command decoder and the response serialiser, and replaces the single-cycle, enable-driven ALU.

## Interface
- DATA_WIDTH, default 8: operand width; legal range ≥2.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operands and opcode valid.
- IN_READY  out  1  block can accept a transfer this cycle.
- A, B  in  DATA_WIDTH  unsigned operands.
- ALU_FUN  in  4  opcode, type Alu_op_e.
- OUT_VALID  out  1  result registered and valid.
- OUT_READY  in  1  downstream consumes the result.
- ALU_OUT  out  2×DATA_WIDTH  result.
- OUT_ZERO  out  1  ALU_OUT == 0.
- OUT_ERR  out  1  divide-by-zero, undefined opcode, or division compiled out.

## Operation
- Opcodes (W = DATA_WIDTH):
  - 0 ADD: {carry, A+B}.
  - 1 SUB: {borrow, A−B mod 2^W}.
  - 2 MUL: full 2W-bit unsigned product.
  - 3 DIV: {remainder, quotient}.
  - 4 AND, 5 OR, 6 NAND = ~(A&B), 7 NOR = ~(A|B), 8 XOR: W-bit logic result, zero-extended.
  - 9 CMP: 1 if A==B, 2 if A>B, 3 if A<B.
  - 10 SHL: A<<1, zero-extended, so bit W can be set.
  - 11 SHR: A>>1.
  - 12–15: ALU_OUT=0, OUT_ERR=1.
- All upper bits not named above are zero. OUT_ZERO is computed from the final ALU_OUT.
- A transfer occurs when IN_VALID && IN_READY.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY), so the output register can be refilled in the same cycle it drains.
- FSM states:
  - IDLE: on a non-DIV transfer (or a DIV with B==0), load the output register and stay in IDLE. On a DIV transfer with B≠0, latch the operands, clear the counter and go to DIV.
  - DIV: restoring division, one quotient bit per cycle, MSB first, for W cycles. On the last iteration, load the output register and go to IDLE.
- Divide-by-zero: quotient all ones, remainder = A, OUT_ERR=1; takes single-cycle latency.
- While OUT_VALID=1 && OUT_READY=0, ALU_OUT and all flags hold stable.
- OUT_VALID falls on the cycle after the transfer is consumed, unless a new result loads in that same cycle.
- Reset (any state, including mid-DIV): the operation is aborted, state=IDLE, and OUT_VALID, ALU_OUT, OUT_ZERO and OUT_ERR all go to 0. IN_READY is 1 after reset deasserts.

## Timing
- Non-DIV ops and DIV-by-zero: OUT_VALID rises on the first edge after the transfer edge (latency 1).
- DIV, B≠0: OUT_VALID rises W+1 edges after the transfer edge. IN_READY=0 throughout.
- Throughput: one non-DIV op per cycle when OUT_READY is held high.
- No combinational path from IN_VALID to OUT_VALID. The path from OUT_READY to IN_READY is combinational.

## Configuration
- ALU_DIV_EN defined: the iterative divider and DIV state are compiled in, with behaviour as above.
- ALU_DIV_EN undefined: no divider logic and no DIV state. Opcode 3 behaves as undefined: ALU_OUT=0, OUT_ERR=1, latency 1.

## Structure
- UART_pkg holds:
  - the DATA_WIDTH default;
  - Alu_op_e, a 4-bit enum with the encodings listed above;
  - the CMP result constants.
- The FSM state enum stays local to the block.
- Sub-module alu_divider contains the restoring divider, operand and partial-remainder registers, and the counter of $clog2(W+1) bits. It has start/done pins and is instantiated only under ALU_DIV_EN.

## Test plan
All scenarios use W=8.
- ADD A=0xFF, B=0x01 -> ALU_OUT=0x0100, OUT_ZERO=0, OUT_ERR=0, OUT_VALID one cycle after the transfer.
- MUL 0xFF×0xFF -> 0xFE01. SUB 0x00−0x01 -> 0x01FF. CMP 3 vs 5 -> 0x0003. XOR 0x5A^0x5A -> 0x0000 with OUT_ZERO=1.
- DIV 200/7 -> ALU_OUT=0x041C, OUT_VALID exactly 9 edges after the transfer, IN_READY low for the whole interval.
- DIV 0x37/0 -> ALU_OUT=0x37FF, OUT_ERR=1, latency 1. Opcode 14 -> ALU_OUT=0, OUT_ERR=1.
- Backpressure: hold OUT_READY=0 and offer ADD then AND.
  - Required: the first result stays stable and IN_READY=0 while the output is full.
  - Releasing OUT_READY for one cycle loads the second result in that same cycle, with no bubble.
- Assert RST on DIV cycle 4 -> all outputs 0 immediately. After release, a new ADD 1+1 returns 0x0002. Also run with ALU_DIV_EN undefined: DIV 200/7 -> OUT_ERR=1, ALU_OUT=0.

Source files
------------

// File: rtl/alu_handshake_pkg.sv
// Shared ALU definitions: default operand width, opcode encodings, CMP result codes.
package UART_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NAND = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_XOR  = 4'd8,
        ALU_CMP  = 4'd9,
        ALU_SHL  = 4'd10,
        ALU_SHR  = 4'd11
    } Alu_op_e;

    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;
    localparam logic [1:0] CMP_LT = 2'd3;

endpackage

// File: rtl/alu_handshake_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// 'done' is asserted for one cycle once all DATA_WIDTH iterations have completed;
// quotient/remainder are valid while 'done' is high.
module alu_divider
    import UART_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    logic [CW-1:0]         cnt_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH:0]   shift_c;
    logic [DATA_WIDTH:0]   trial_c;

    // Shift next dividend bit into the partial remainder and trial-subtract the divisor.
    always_comb begin
        shift_c = {rem_q, quo_q[DATA_WIDTH-1]};
        trial_c = shift_c - {1'b0, dvs_q};
    end

    assign done      = busy_q && (cnt_q == CW'(DATA_WIDTH));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Operand latch on start, then one restoring step per cycle until the count reaches W.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            dvs_q  <= divisor;
            quo_q  <= dividend;
            rem_q  <= '0;
        end else if (busy_q) begin
            if (cnt_q != CW'(DATA_WIDTH)) begin
                cnt_q <= cnt_q + CW'(1);
                if (!trial_c[DATA_WIDTH]) begin
                    rem_q <= trial_c[DATA_WIDTH-1:0];
                    quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shift_c[DATA_WIDTH-1:0];
                    quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
                end
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_handshake.sv
// Handshaked ALU with registered 2*DATA_WIDTH result and status flags.
// Build option ALU_DIV_EN: compiles in the iterative divider and DIV state;
// without it, opcode 3 is treated as undefined.
module alu_handshake
    import UART_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [DATA_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   B,
    input  logic [3:0]              ALU_FUN,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [2*DATA_WIDTH-1:0] ALU_OUT,
    output logic                    OUT_ZERO,
    output logic                    OUT_ERR
);

    localparam int unsigned W2 = 2 * DATA_WIDTH;

`ifdef ALU_DIV_EN
    typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_e;
`else
    typedef enum logic {S_IDLE = 1'b0} state_e;
`endif

    state_e          state_q, state_d;
    logic            xfer;
    logic [W2-1:0]   res_c;
    logic            err_c;
    logic            load;
    logic [W2-1:0]   load_val;
    logic            load_err;
    logic            valid_q;
    logic [W2-1:0]   out_q;
    logic            zero_q;
    logic            err_q;
    logic [DATA_WIDTH:0] sum_c;
    logic [DATA_WIDTH:0] diff_c;

`ifdef ALU_DIV_EN
    logic                  div_go;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quo;
    logic [DATA_WIDTH-1:0] div_rem;

    alu_divider #(.DATA_WIDTH(DATA_WIDTH)) u_div (
        .CLK       (CLK),
        .RST       (RST),
        .start     (xfer && div_go),
        .dividend  (A),
        .divisor   (B),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    assign IN_READY  = (state_q == S_IDLE) && (!valid_q || OUT_READY);
    assign xfer      = IN_VALID && IN_READY;
    assign OUT_VALID = valid_q;
    assign ALU_OUT   = out_q;
    assign OUT_ZERO  = zero_q;
    assign OUT_ERR   = err_q;

    // Single-cycle result for every opcode except a DIV with a non-zero divisor.
    always_comb begin
        res_c  = '0;
        err_c  = 1'b0;
        sum_c  = {1'b0, A} + {1'b0, B};
        diff_c = {1'b0, A} - {1'b0, B};
`ifdef ALU_DIV_EN
        div_go = 1'b0;
`endif
        case (ALU_FUN)
            ALU_ADD:  res_c[DATA_WIDTH:0] = sum_c;
            ALU_SUB:  res_c[DATA_WIDTH:0] = diff_c;
            ALU_MUL:  res_c = {{DATA_WIDTH{1'b0}}, A} * {{DATA_WIDTH{1'b0}}, B};
            ALU_DIV: begin
`ifdef ALU_DIV_EN
                if (B == '0) begin
                    res_c = {A, {DATA_WIDTH{1'b1}}};
                    err_c = 1'b1;
                end else begin
                    div_go = 1'b1;
                end
`else
                err_c = 1'b1;
`endif
            end
            ALU_AND:  res_c[DATA_WIDTH-1:0] = A & B;
            ALU_OR:   res_c[DATA_WIDTH-1:0] = A | B;
            ALU_NAND: res_c[DATA_WIDTH-1:0] = ~(A & B);
            ALU_NOR:  res_c[DATA_WIDTH-1:0] = ~(A | B);
            ALU_XOR:  res_c[DATA_WIDTH-1:0] = A ^ B;
            ALU_CMP: begin
                if (A == B)     res_c[1:0] = CMP_EQ;
                else if (A > B) res_c[1:0] = CMP_GT;
                else            res_c[1:0] = CMP_LT;
            end
            ALU_SHL:  res_c[DATA_WIDTH:0] = {A, 1'b0};
            ALU_SHR:  res_c[DATA_WIDTH-1:0] = A >> 1;
            default:  err_c = 1'b1;
        endcase
    end

    // Next state and output-register load selection.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = res_c;
        load_err = err_c;
        case (state_q)
            S_IDLE: begin
`ifdef ALU_DIV_EN
                if (xfer && div_go) begin
                    state_d = S_DIV;
                end else if (xfer) begin
                    load = 1'b1;
                end
`else
                load = xfer;
`endif
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                if (div_done) begin
                    load     = 1'b1;
                    load_val = {div_rem, div_quo};
                    load_err = 1'b0;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Output register: a load takes priority over draining, so refill needs no bubble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            out_q   <= load_val;
            zero_q  <= (load_val == '0);
            err_q   <= load_err;
        end else if (OUT_READY) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_handshake.sv
// Directed bench for alu_handshake at DATA_WIDTH=8; DIV expectations follow ALU_DIV_EN.
module tb_alu_handshake;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [3:0]    ALU_FUN;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [2*DW-1:0] ALU_OUT;
    logic          OUT_ZERO;
    logic          OUT_ERR;

    int n_cmp = 0;
    int n_err = 0;

    alu_handshake #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ALU_OUT   (ALU_OUT),
        .OUT_ZERO  (OUT_ZERO),
        .OUT_ERR   (OUT_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        IN_VALID = 1'b1;
        ALU_FUN  = op;
        A        = a;
        B        = b;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] v, input logic z, input logic e);
        chk({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        chk({tag, "_out"},   32'(ALU_OUT),   32'(v));
        chk({tag, "_zero"},  32'(OUT_ZERO),  32'(z));
        chk({tag, "_err"},   32'(OUT_ERR),   32'(e));
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = '0; OUT_READY = 1'b1;
        #2;
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_out",   32'(ALU_OUT),   32'd0);
        chk("rst_zero",  32'(OUT_ZERO),  32'd0);
        chk("rst_err",   32'(OUT_ERR),   32'd0);
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("rst_inready", 32'(IN_READY), 32'd1);

        // Back-to-back single-cycle ops with OUT_READY held high.
        offer(4'd0, 8'hFF, 8'h01); tick(); chk_out("add", 16'h0100, 1'b0, 1'b0);
        offer(4'd2, 8'hFF, 8'hFF); tick(); chk_out("mul", 16'hFE01, 1'b0, 1'b0);
        offer(4'd1, 8'h00, 8'h01); tick(); chk_out("sub", 16'h01FF, 1'b0, 1'b0);
        offer(4'd9, 8'h03, 8'h05); tick(); chk_out("cmp", 16'h0003, 1'b0, 1'b0);
        offer(4'd8, 8'h5A, 8'h5A); tick(); chk_out("xor", 16'h0000, 1'b1, 1'b0);
        offer(4'd10, 8'h81, 8'h00); tick(); chk_out("shl", 16'h0102, 1'b0, 1'b0);
        offer(4'd6, 8'hF0, 8'h3C); tick(); chk_out("nand", 16'h00CF, 1'b0, 1'b0);
        IN_VALID = 1'b0;
        tick();
        chk("drain_valid", 32'(OUT_VALID), 32'd0);

        // DIV 200/7.
        offer(4'd3, 8'd200, 8'd7);
        tick();
        IN_VALID = 1'b0;
`ifdef ALU_DIV_EN
        chk("div_ready_e0", 32'(IN_READY), 32'd0);
        chk("div_valid_e0", 32'(OUT_VALID), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("div_ready_e%0d", i), 32'(IN_READY), 32'd0);
            chk($sformatf("div_valid_e%0d", i), 32'(OUT_VALID), 32'd0);
        end
        tick();
        chk_out("div", 16'h041C, 1'b0, 1'b0);
`else
        chk_out("div_off", 16'h0000, 1'b1, 1'b1);
`endif

        // Divide by zero and undefined opcode, both single-cycle.
        offer(4'd3, 8'h37, 8'h00); tick();
`ifdef ALU_DIV_EN
        chk_out("div0", 16'h37FF, 1'b0, 1'b1);
`else
        chk_out("div0_off", 16'h0000, 1'b1, 1'b1);
`endif
        offer(4'd14, 8'h12, 8'h34); tick(); chk_out("op14", 16'h0000, 1'b1, 1'b1);
        IN_VALID = 1'b0;
        tick();

        // Backpressure: first result must hold while the second waits.
        OUT_READY = 1'b0;
        offer(4'd0, 8'h03, 8'h04); tick();
        chk_out("bp_add", 16'h0007, 1'b0, 1'b0);
        offer(4'd4, 8'h0F, 8'h3C);
        #1;
        chk("bp_ready0", 32'(IN_READY), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("bp_hold%0d", i), 16'h0007, 1'b0, 1'b0);
            chk($sformatf("bp_ready_h%0d", i), 32'(IN_READY), 32'd0);
        end
        OUT_READY = 1'b1;
        #1;
        chk("bp_ready1", 32'(IN_READY), 32'd1);
        tick();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        chk_out("bp_and", 16'h000C, 1'b0, 1'b0);
        tick();
        chk_out("bp_and_hold", 16'h000C, 1'b0, 1'b0);
        OUT_READY = 1'b1;
        tick();
        chk("bp_drain", 32'(OUT_VALID), 32'd0);

        // Reset in the middle of a division (ALU_OUT still holds the drained AND result).
        offer(4'd3, 8'd200, 8'd7);
        tick();
        IN_VALID = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        #1;
        chk("mrst_valid", 32'(OUT_VALID), 32'd0);
        chk("mrst_out",   32'(ALU_OUT),   32'd0);
        chk("mrst_zero",  32'(OUT_ZERO),  32'd0);
        chk("mrst_err",   32'(OUT_ERR),   32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("mrst_ready", 32'(IN_READY), 32'd1);
        repeat (9) tick();
        chk("mrst_no_stale", 32'(OUT_VALID), 32'd0);
        offer(4'd0, 8'd1, 8'd1); tick();
        chk_out("mrst_add", 16'h0002, 1'b0, 1'b0);
        IN_VALID = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
